// File: rtl/nbit_serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single borrow flop carries between bit slices, so the datapath is one
// full-subtractor cell regardless of N. Valid/ready handshake on both sides.
module nbit_serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  // Bit counter must index 0..N-1 and is never narrower than one bit.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, b_q, diff_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic          bout_q, zero_q, ovf_q;

  // Single full-subtractor slice working on the current LSBs.
  logic          a_bit, b_bit, d_bit, br_nxt, last_bit;
  logic [N-1:0]  diff_shift;

  // Bit-slice arithmetic and the diff value after this slice shifts in.
  always_comb begin
    a_bit      = a_q[0];
    b_bit      = b_q[0];
    d_bit      = a_bit ^ b_bit ^ br_q;
    br_nxt     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    last_bit   = (cnt_q == LAST_BIT);
    diff_shift = (diff_q >> 1) | (N'(d_bit) << (N - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, run N bit edges, wait for consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode purely from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand capture, serial shifting and result latching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_nxt;
          diff_q <= diff_shift;
          if (last_bit) begin
            // br_q here is the borrow into the MSB slice.
            bout_q <= br_nxt;
            ovf_q  <= br_q ^ br_nxt;
            zero_q <= (diff_shift == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // DONE: results held until the consumer takes them.
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule
